// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared instruction-memory parameters and loader state encoding
// Purpose: common types and constants for the boot-time instruction loader.
// Ports: none (package).
package mips_pkg;

  localparam int IMEM_ADDR_W = 16;
  localparam int IMEM_SIZE   = 16000;
  localparam int WORD_W      = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - big-endian 4-byte to 32-bit word assembler
// Purpose: shifts accepted bytes in MSB-first and flags the byte that completes a word.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clear_i        drops any partial word and restarts at byte 0
//   byte_valid_i   a byte is accepted this cycle
//   byte_data_i    the accepted byte
//   word_valid_o   this cycle's byte completes a word (combinational)
//   word_data_o    the completed word, valid with word_valid_o
module byte_packer
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_data_o
);

  logic [1:0]  cnt_q;
  logic [23:0] shreg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      shreg_q <= 24'd0;
    end else if (clear_i) begin
      cnt_q   <= 2'd0;
      shreg_q <= 24'd0;
    end else if (byte_valid_i) begin
      cnt_q   <= cnt_q + 2'd1;  // wraps 3 -> 0 at each word boundary
      shreg_q <= {shreg_q[15:0], byte_data_i};
    end
  end

  // The completed word is presented in the same cycle as its 4th byte so the
  // loader can register the write strobe exactly one cycle later.
  assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);
  assign word_data_o  = {shreg_q, byte_data_i};

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - parses a length-prefixed byte image into instruction-memory writes
// Purpose: boot loader between the UART receiver and the instruction memory write port.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          arms a new load from any state
//   rx_valid       received-byte strobe, rx_data holds the byte
//   write_enable   one-cycle write strobe, address/write_data valid with it
//   loading        high in HEADER or DATA
//   done           image fully written (level until start/reset)
//   error          image length exceeded MEM_SIZE (level until start/reset)
module instruction_loader
  import mips_pkg::*;
#(
  parameter int MEM_SIZE = IMEM_SIZE,
  parameter int ADDR_W   = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              write_enable,
  output logic [ADDR_W-1:0] address,
  output logic [WORD_W-1:0] write_data,
  output logic              loading,
  output logic              done,
  output logic              error
);

  localparam logic [31:0] MaxWords = 32'(MEM_SIZE);

  state_e              state_q;
  logic [31:0]         n_q;
  logic [ADDR_W-1:0]   word_cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic                loading_q;
  logic                done_q;
  logic                error_q;

  logic                accept;
  logic                word_valid;
  logic [WORD_W-1:0]   word_data;
  logic [31:0]         words_written_d;

  // start wins over a coincident byte; bytes outside HEADER/DATA are dropped.
  assign accept = rx_valid && !start && (state_q == ST_HEADER || state_q == ST_DATA);

  byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (start),
    .byte_valid_i (accept),
    .byte_data_i  (rx_data),
    .word_valid_o (word_valid),
    .word_data_o  (word_data)
  );

  // Count including the word being written now, widened so the compare
  // against the full 32-bit N never truncates.
  assign words_written_d = {{(32-ADDR_W){1'b0}}, word_cnt_q} + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      n_q        <= 32'd0;
      word_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      loading_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (start) begin
        state_q    <= ST_HEADER;
        n_q        <= 32'd0;
        word_cnt_q <= '0;
        loading_q  <= 1'b1;
        done_q     <= 1'b0;
        error_q    <= 1'b0;
      end else if (word_valid) begin
        case (state_q)
          ST_HEADER: begin
            n_q <= word_data;
            if (word_data == 32'd0) begin
              state_q   <= ST_DONE;
              loading_q <= 1'b0;
              done_q    <= 1'b1;
            end else if (word_data > MaxWords) begin
              state_q   <= ST_ERROR;
              loading_q <= 1'b0;
              error_q   <= 1'b1;
            end else begin
              state_q <= ST_DATA;
            end
          end
          ST_DATA: begin
            we_q       <= 1'b1;
            addr_q     <= word_cnt_q;
            wdata_q    <= word_data;
            word_cnt_q <= word_cnt_q + ADDR_W'(1);
            if (words_written_d == n_q) begin
              state_q   <= ST_DONE;
              loading_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign write_enable = we_q;
  assign address      = addr_q;
  assign write_data   = wdata_q;
  assign loading      = loading_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - self-checking bench for instruction_loader
module tb_instruction_loader;

  typedef struct {
    logic        s;
    logic        v;
    logic [7:0]  d;
    logic        we;
    logic [15:0] a;
    logic [31:0] wd;
    logic        ld;
    logic        dn;
    logic        er;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        write_enable;
  logic [15:0] address;
  logic [31:0] write_data;
  logic        loading;
  logic        done;
  logic        error;

  int tests = 0;
  int fails = 0;

  logic [15:0] wq_addr[$];
  logic [31:0] wq_data[$];

  vec_t tbl[15];

  instruction_loader #(.MEM_SIZE(16000), .ADDR_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .write_enable (write_enable),
    .address      (address),
    .write_data   (write_data),
    .loading      (loading),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_enable) begin
      wq_addr.push_back(address);
      wq_data.push_back(write_data);
    end
  end

  function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d,
                              input logic we, input logic [15:0] a, input logic [31:0] wd,
                              input logic ld, input logic dn, input logic er);
    vec_t r;
    r.s = s; r.v = v; r.d = d; r.we = we; r.a = a; r.wd = wd;
    r.ld = ld; r.dn = dn; r.er = er;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic v, input logic [7:0] d);
    start = s; rx_valid = v; rx_data = d;
    @(posedge clk); #1;
    start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b0, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic send_list(input logic [7:0] b[$]);
    foreach (b[i]) send(b[i]);
  endtask

  initial begin
    logic [7:0]  bytes[$];
    logic [31:0] exp_w[3];

    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {13'd0, write_enable, address, write_data, loading, done, error}, 64'd0);
    rst_n = 1'b1;
    idle(2);
    // Bytes in IDLE are ignored.
    send(8'h00); send(8'h00); send(8'h00); send(8'h01);
    chk("idle_ignored", {60'd0, write_enable, loading, done, error}, 64'd0);

    // Back-to-back N=2 image, cycle by cycle.
    tbl[0]  = mk(1, 0, 8'h00, 0, 16'd0, 32'h0,        1, 0, 0);
    tbl[1]  = mk(0, 1, 8'h00, 0, 16'd0, 32'h0,        1, 0, 0);
    tbl[2]  = mk(0, 1, 8'h00, 0, 16'd0, 32'h0,        1, 0, 0);
    tbl[3]  = mk(0, 1, 8'h00, 0, 16'd0, 32'h0,        1, 0, 0);
    tbl[4]  = mk(0, 1, 8'h02, 0, 16'd0, 32'h0,        1, 0, 0);
    tbl[5]  = mk(0, 1, 8'hDE, 0, 16'd0, 32'h0,        1, 0, 0);
    tbl[6]  = mk(0, 1, 8'hAD, 0, 16'd0, 32'h0,        1, 0, 0);
    tbl[7]  = mk(0, 1, 8'hBE, 0, 16'd0, 32'h0,        1, 0, 0);
    tbl[8]  = mk(0, 1, 8'hEF, 1, 16'd0, 32'hDEADBEEF, 1, 0, 0);
    tbl[9]  = mk(0, 1, 8'h01, 0, 16'd0, 32'hDEADBEEF, 1, 0, 0);
    tbl[10] = mk(0, 1, 8'h23, 0, 16'd0, 32'hDEADBEEF, 1, 0, 0);
    tbl[11] = mk(0, 1, 8'h45, 0, 16'd0, 32'hDEADBEEF, 1, 0, 0);
    tbl[12] = mk(0, 1, 8'h67, 1, 16'd1, 32'h01234567, 0, 1, 0);
    tbl[13] = mk(0, 0, 8'h00, 0, 16'd1, 32'h01234567, 0, 1, 0);
    tbl[14] = mk(0, 1, 8'h55, 0, 16'd1, 32'h01234567, 0, 1, 0);
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].s, tbl[i].v, tbl[i].d);
      chk($sformatf("b2b_row%0d", i),
          {13'd0, write_enable, address, write_data, loading, done, error},
          {13'd0, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].ld, tbl[i].dn, tbl[i].er});
    end

    // N=0: done one cycle after the 4th header byte, trailing bytes ignored.
    clear_q();
    cyc(1, 0, 8'h00);
    send(8'h00); send(8'h00); send(8'h00);
    chk("n0_not_done_yet", {63'd0, done}, 64'd0);
    send(8'h00);
    chk("n0_done", {62'd0, loading, done}, 64'd1);
    send_list('{8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h02});
    idle(1);
    chk("n0_no_writes", 64'(wq_addr.size()), 64'd0);
    chk("n0_done_held", {63'd0, done}, 64'd1);

    // N=16001: error, then recovery with N=1.
    cyc(1, 0, 8'h00);
    send_list('{8'h00, 8'h00, 8'h3E});
    chk("big_no_error_yet", {63'd0, error}, 64'd0);
    send(8'h81);
    chk("big_error", {61'd0, loading, done, error}, 64'd1);
    send_list('{8'h00, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44});
    idle(1);
    chk("big_no_writes", 64'(wq_addr.size()), 64'd0);
    chk("big_error_held", {63'd0, error}, 64'd1);
    cyc(1, 0, 8'h00);
    chk("start_clears_error", {62'd0, loading, error}, 64'd2);
    send_list('{8'h00, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44});
    idle(1);
    chk("recover_count", 64'(wq_addr.size()), 64'd1);
    if (wq_addr.size() == 1)
      chk("recover_write", {16'd0, wq_addr[0], wq_data[0]}, {32'd0, 32'h11223344});
    chk("recover_flags", {62'd0, done, error}, 64'd2);

    // N whose low 16 bits look small must still be rejected.
    cyc(1, 0, 8'h00);
    send_list('{8'h00, 8'h01, 8'h00, 8'h01});
    chk("no_truncation_error", {62'd0, loading, error}, 64'd1);
    // N=16000 exactly is accepted.
    cyc(1, 0, 8'h00);
    send_list('{8'h00, 8'h00, 8'h3E, 8'h80});
    chk("max_size_accepted", {61'd0, loading, done, error}, 64'd4);

    // N=3 with random gaps.
    clear_q();
    cyc(1, 0, 8'h00);
    bytes = '{8'h00, 8'h00, 8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
              8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    exp_w[0] = 32'hDEADBEEF; exp_w[1] = 32'h01234567; exp_w[2] = 32'h89ABCDEF;
    foreach (bytes[i]) begin
      send(bytes[i]);
      idle($urandom_range(0, 20));
    end
    idle(1);
    chk("gaps_count", 64'(wq_addr.size()), 64'd3);
    if (wq_addr.size() == 3)
      for (int i = 0; i < 3; i++)
        chk($sformatf("gaps_write%0d", i), {16'd0, wq_addr[i], wq_data[i]},
            {16'd0, 16'(i), exp_w[i]});
    chk("gaps_done", {62'd0, loading, done}, 64'd1);

    // start mid-word aborts the partial word.
    cyc(1, 0, 8'h00);
    send_list('{8'h00, 8'h00, 8'h00, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60});
    clear_q();
    cyc(1, 0, 8'h00);
    send_list('{8'h00, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
    idle(2);
    chk("abort_count", 64'(wq_addr.size()), 64'd1);
    if (wq_addr.size() == 1)
      chk("abort_write", {16'd0, wq_addr[0], wq_data[0]}, {32'd0, 32'hAABBCCDD});
    chk("abort_done", {63'd0, done}, 64'd1);

    // start coincident with the 4th byte: byte dropped, strobe suppressed.
    cyc(1, 0, 8'h00);
    send_list('{8'h00, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33});
    clear_q();
    cyc(1, 1, 8'h44);
    idle(2);
    chk("coinc_no_write", {31'd0, 16'(wq_addr.size()), 14'd0, loading, done, error}, {31'd0, 16'd0, 14'd0, 3'b100});
    send_list('{8'h00, 8'h00, 8'h00, 8'h01, 8'h55, 8'h66, 8'h77, 8'h88});
    idle(1);
    chk("coinc_next_count", 64'(wq_addr.size()), 64'd1);
    if (wq_addr.size() == 1)
      chk("coinc_next_write", {16'd0, wq_addr[0], wq_data[0]}, {32'd0, 32'h55667788});

    // Asynchronous reset between bytes 3 and 4 of a word.
    cyc(1, 0, 8'h00);
    send_list('{8'h00, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE});
    chk("pre_reset_state", {30'd0, address, write_data, loading, done}, {30'd0, 16'd0, 32'h12345678, 2'b10});
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {13'd0, write_enable, address, write_data, loading, done, error}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_q();
    send(8'hF0);
    idle(2);
    chk("post_reset_ignored", {31'd0, 16'(wq_addr.size()), 14'd0, loading, done, error}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Boot-time writer for the instruction memory. Consumes a byte stream from the host link (UART receiver), parses a length-prefixed program image, assembles big-endian 32-bit words, and drives the memory's write port (`write_enable`, `address`, `write_data`) one word per write pulse. It sits between the serial receiver and the instruction memory. `done` releases the core to start fetching.

## Interface
- `MEM_SIZE`, 16000: capacity in words; images longer than this are rejected.
- `ADDR_W`, 16: address width, matching the memory's 16-bit address port.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse that arms a new load; honoured in any state.
- `rx_valid`  in  1  single-cycle strobe; `rx_data` holds a received byte.
- `rx_data`  in  8  received byte.
- `write_enable`  out  1  one-cycle write strobe to instruction memory.
- `address`  out  ADDR_W  word address for the write.
- `write_data`  out  32  word to write.
- `loading`  out  1  high while in HEADER or DATA.
- `done`  out  1  image fully written; level, held until next `start`/reset.
- `error`  out  1  image length > MEM_SIZE; level, held until next `start`/reset.

## Operation
- Image format: 4-byte word count N (big-endian), then N words, each 4 bytes big-endian. First byte lands in bits [31:24].
- States:
  - IDLE: `rx_valid` ignored.
  - HEADER: collect 4 bytes into N.
  - DATA: collect words.
  - DONE.
  - ERROR.
- Transitions:
  - `start` from any state -> HEADER. Clears byte counter, word counter, `done`, `error`; aborts any partial word.
  - HEADER, 4th byte: N=0 -> DONE; N>MEM_SIZE -> ERROR; otherwise -> DATA.
  - DATA, 4th byte of word k: issue write of word k to address k. After word N-1 is written -> DONE.
  - DONE/ERROR: stay; `rx_valid` ignored.
- Byte counter: 2 bits, wraps 3->0 per word. Word counter: ADDR_W bits, compared against N (32-bit compare; N is never truncated before the check).
- Bytes arriving in IDLE, DONE or ERROR are dropped silently.
- Reset values: `write_enable`=0, `address`=0, `write_data`=0, `loading`=0, `done`=0, `error`=0; state=IDLE.

## Timing
- `rx_valid` needs no backpressure. Any rate up to one byte per cycle must be accepted, including back-to-back.
- Write latency: `write_enable` is high in the cycle after the `rx_valid` that carries the 4th byte of a word. It is high for exactly one cycle, with `address`/`write_data` valid in that same cycle.
- `address`/`write_data` hold their last values after the strobe, for waveform readability only.
- A byte accepted in the same cycle as `write_enable` is captured normally; the assembly register is independent of `write_data`.
- `done` rises in the same cycle as the final `write_enable`. `loading` falls in that cycle.
- `error` rises the cycle after the 4th header byte.
- `start` coincident with `rx_valid`: `start` wins; the byte is dropped.
- `start` coincident with a pending write strobe: the strobe is suppressed.
- `rst_n` asserted mid-load: all outputs go to reset values immediately (async). The partially written memory is left as is.

## Structure
- Shared package `mips_pkg`:
  - state enum (IDLE, HEADER, DATA, DONE, ERROR)
  - `IMEM_ADDR_W` = 16
  - `IMEM_SIZE` = 16000
  - word width 32
- One natural sub-module: `byte_packer`, a 4-byte big-endian shift/assemble stage with a 2-bit counter and `word_valid` pulse. It is reused for the header and the data words. The FSM, counters and length check stay in `instruction_loader`.

## Test plan
- Reset then image N=2, bytes `00 00 00 02 DE AD BE EF 01 23 45 67` back-to-back:
  - writes `DEADBEEF`@0 and `01234567`@1, each a single-cycle strobe one cycle after the 4th byte;
  - `done`=1 with the second strobe.
- N=0 (`00 00 00 00`): no `write_enable`; `done` one cycle after the 4th byte; trailing bytes ignored.
- N=16001: `error`=1 after the header, no writes for the following bytes. A subsequent `start` plus a valid N=1 image writes @0 and clears `error`.
- Bytes spaced by random 0-20 idle cycles, N=3: identical writes and addresses to the back-to-back case.
- `start` after 2 bytes of word 1 (of N=4), then a fresh N=1 image `AA BB CC DD`: exactly one write, `AABBCCDD`@0, no stale bytes.
- `rst_n` pulsed low between byte 3 and byte 4 of a word:
  - all outputs 0 asynchronously;
  - after release, the 4th byte is ignored (IDLE) and no write occurs.
